// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state type for the scoreboarded GPR file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic {RF_INIT, RF_READY} rf_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register mux, write->read bypass and busy lookup.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              active,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0]  busy,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);

  // A bypass hit forwards the in-flight write and reports the register as free.
  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (active && re && (raddr != '0)) begin
      if (byp_en && (byp_addr == raddr)) begin
        rdata = byp_data;
        rbusy = 1'b0;
      end else begin
        rdata = regs[raddr];
        rbusy = busy[raddr];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port GPR file with issue/writeback scoreboard and post-reset zeroing.
// Optional same-cycle write->read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_t         state;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_hit;
  logic              active;
  logic              byp_en;

  assign wr_hit = we && (waddr != '0);
  assign active = rst && (state == RF_READY);

`ifdef REGFILE_BYPASS_EN
  assign byp_en = wr_hit;
`else
  assign byp_en = 1'b0;
`endif

  // Apply flush, then writeback clear, then issue set so a new producer always wins.
  always_comb begin
    busy_nxt = flush ? '0 : busy;
    if (wr_hit)
      busy_nxt[waddr] = 1'b0;
    if (iss_valid && (iss_addr != '0))
      busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RF_INIT;
      init_ptr  <= '0;
      init_done <= 1'b0;
      busy      <= '0;
    end else begin
      case (state)
        RF_INIT: begin
          init_ptr <= init_ptr + ADDR_W'(1);
          if (init_ptr == ADDR_W'(DEPTH - 1)) begin
            state     <= RF_READY;
            init_done <= 1'b1;
          end
        end
        RF_READY: begin
          busy <= busy_nxt;
        end
        default: begin
          state <= RF_INIT;
        end
      endcase
    end
  end

  // The array has no reset; the INIT sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == RF_INIT)
      regs[init_ptr] <= DATA_W'(ZERO_WORD);
    else if (wr_hit)
      regs[waddr] <= wdata;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) u_rd (
      .active  (active),
      .re      (re[p]),
      .raddr   (raddr[p*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .busy    (busy),
      .byp_en  (byp_en),
      .byp_addr(waddr),
      .byp_data(wdata),
      .rdata   (rdata[p*DATA_W +: DATA_W]),
      .rbusy   (rbusy[p])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk;
  logic            rst;
  logic            init_done;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [NR-1:0]   re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]   rbusy;
  logic            iss_valid;
  logic [AW-1:0]   iss_addr;
  logic            flush;

  typedef struct {
    string       name;
    bit          is_init;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .init_done(init_done),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one queued expectation against what the DUT presents right now.
  task automatic checkOutput(input exp_t e);
    logic [31:0] act_d;
    logic        act_b;
    checks++;
    if (e.is_init) begin
      if (init_done !== e.busy) begin
        errors++;
        $display("[TB] FAIL %s: init_done got %b, expected %b", e.name, init_done, e.busy);
      end
    end else begin
      act_d = rdata[e.port*DW +: DW];
      act_b = rbusy[e.port];
      if (act_d !== e.data || act_b !== e.busy) begin
        errors++;
        $display("[TB] FAIL %s: port%0d got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, e.port, act_d, act_b, e.data, e.busy);
      end
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic applyStimulus(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic iv, input logic [AW-1:0] ia, input logic fl,
                               input logic [NR-1:0] r, input logic [AW-1:0] ra0,
                               input logic [AW-1:0] ra1);
    we = w; waddr = wa; wdata = wd;
    iss_valid = iv; iss_addr = ia; flush = fl;
    re = r; raddr = {ra1, ra0};
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_port(input string n, input int p, input logic [31:0] d, input logic b);
    exp_t e;
    e.name = n; e.is_init = 1'b0; e.port = p; e.data = d; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_init(input string n, input logic v);
    exp_t e;
    e.name = n; e.is_init = 1'b1; e.port = 0; e.data = '0; e.busy = v;
    exp_q.push_back(e);
  endtask

  logic [31:0] exp_byp;

  initial begin
    rst = 1'b0;
    idle();
    step();
    step();

    // 1. Zeroing sequence: init_done low for 32 edges, then high; every index reads 0.
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b01, AW'(i), '0);
      expect_init("init_low", 1'b0);
      expect_port("init_read", 0, ZERO_WORD, 1'b0);
      step();
    end
    idle();
    expect_init("init_high", 1'b1);
    step();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b11, AW'(i), AW'(31 - i));
      expect_port("zero_p0", 0, ZERO_WORD, 1'b0);
      expect_port("zero_p1", 1, ZERO_WORD, 1'b0);
      step();
    end

    // 2. Basic write/read and r0 immunity.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, 2'b00, '0, '0);
    step();
    applyStimulus(1'b1, 5'd0, 32'h1, 1'b0, '0, 1'b0, 2'b10, '0, 5'd5);
    expect_port("r5_read", 1, 32'hDEADBEEF, 1'b0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b11, 5'd0, 5'd0);
    expect_port("r0_p0", 0, ZERO_WORD, 1'b0);
    expect_port("r0_p1", 1, ZERO_WORD, 1'b0);
    step();

    // 3. Same-cycle write and read of r7.
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h1234;
`else
    exp_byp = 32'h0;
`endif
    applyStimulus(1'b1, 5'd7, 32'h1234, 1'b0, '0, 1'b0, 2'b01, 5'd7, '0);
    expect_port("r7_same_cycle", 0, exp_byp, 1'b0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b01, 5'd7, '0);
    expect_port("r7_next_cycle", 0, 32'h1234, 1'b0);
    step();

    // 4. Scoreboard set/clear and issue-beats-writeback.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, 2'b00, '0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b01, 5'd3, '0);
    expect_port("r3_busy", 0, 32'h0, 1'b1);
    step();
    applyStimulus(1'b1, 5'd3, 32'h55, 1'b0, '0, 1'b0, 2'b00, '0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b10, '0, 5'd3);
    expect_port("r3_cleared", 1, 32'h55, 1'b0);
    step();
    applyStimulus(1'b1, 5'd3, 32'h66, 1'b1, 5'd3, 1'b0, 2'b00, '0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b01, 5'd3, '0);
    expect_port("r3_issue_wins", 0, 32'h66, 1'b1);
    step();

    // 5. Flush drops all producers except the one issued alongside it.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd1, 1'b0, 2'b00, '0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd2, 1'b0, 2'b00, '0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd4, 1'b0, 2'b00, '0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b11, 5'd1, 5'd4);
    expect_port("r1_busy", 0, 32'h0, 1'b1);
    expect_port("r4_busy", 1, 32'h0, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 1'b1, 2'b00, '0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b11, 5'd9, 5'd1);
    expect_port("r9_busy_after_flush", 0, 32'h0, 1'b1);
    expect_port("r1_flushed", 1, 32'h0, 1'b0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b11, 5'd2, 5'd3);
    expect_port("r2_flushed", 0, 32'h0, 1'b0);
    expect_port("r3_flushed", 1, 32'h66, 1'b0);
    step();

    // 6. Reset mid-traffic, with writes/issues/flush ignored during the rerun INIT.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd8, 1'b0, 2'b00, '0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b11, 5'd5, 5'd8);
    expect_port("r5_before_reset", 0, 32'hDEADBEEF, 1'b0);
    expect_port("r8_before_reset", 1, 32'h0, 1'b1);
    step();
    rst = 1'b0;
    expect_port("r5_in_reset", 0, ZERO_WORD, 1'b0);
    expect_port("r8_in_reset", 1, ZERO_WORD, 1'b0);
    expect_init("init_in_reset", 1'b0);
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 5'd5, 32'hFFFF, 1'b1, 5'd6, 1'b1, 2'b11, 5'd5, 5'd6);
      expect_init("reinit_low", 1'b0);
      step();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b11, 5'd5, 5'd6);
    expect_init("reinit_high", 1'b1);
    expect_port("r5_rezeroed", 0, ZERO_WORD, 1'b0);
    expect_port("r6_not_busy", 1, ZERO_WORD, 1'b0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'b01, 5'd8, '0);
    expect_port("r8_busy_cleared", 0, ZERO_WORD, 1'b0);
    step();
    idle();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
